// File: rtl/crypto_job_sched.sv
// Crypto job sequencer: splits a CSR job into 4KB-safe read-then-write DMA bursts around a key load.
// Optional watchdog on the wait states is compiled in with SCHED_TIMEOUT_EN.
module crypto_job_sched #(
  parameter int unsigned MAX_BURST_BYTES = 256,
  parameter int unsigned TIMEOUT_CYCLES  = 65535
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_start,
  input  logic [31:0]  i_base_addr,
  input  logic [31:0]  i_len,
  input  logic         i_algo_sel,
  input  logic         i_enc_dec,
  input  logic [127:0] i_key,
  output logic         o_key_load,
  output logic         o_algo_sel,
  output logic         o_enc_dec,
  output logic [127:0] o_key,
  input  logic         i_key_ready,
  output logic         o_rd_cmd_valid,
  input  logic         i_rd_cmd_ready,
  output logic [31:0]  o_rd_cmd_addr,
  output logic [12:0]  o_rd_cmd_len,
  input  logic         i_rd_done,
  input  logic         i_rd_err,
  output logic         o_wr_cmd_valid,
  input  logic         i_wr_cmd_ready,
  output logic [31:0]  o_wr_cmd_addr,
  output logic [12:0]  o_wr_cmd_len,
  input  logic         i_wr_done,
  input  logic         i_wr_err,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_error
);

  localparam logic [3:0] IDLE     = 4'd0;
  localparam logic [3:0] CHECK    = 4'd1;
  localparam logic [3:0] KEY_LOAD = 4'd2;
  localparam logic [3:0] KEY_WAIT = 4'd3;
  localparam logic [3:0] RD_CMD   = 4'd4;
  localparam logic [3:0] RD_WAIT  = 4'd5;
  localparam logic [3:0] WR_CMD   = 4'd6;
  localparam logic [3:0] WR_WAIT  = 4'd7;
  localparam logic [3:0] DONE     = 4'd8;
  localparam logic [3:0] ERR      = 4'd9;

  logic [3:0]  state, nxt;
  logic [31:0] cur_addr, remaining, addr_after, rem_after;
  logic [12:0] burst;
  logic        in_wait, active, wdog_hit;

  // Largest burst that fits the job remainder and stops at the next 4KB line.
  function automatic logic [12:0] calc_burst(input logic [31:0] a, input logic [31:0] r);
    logic [32:0] b;
    logic [32:0] room;
    b = 33'(MAX_BURST_BYTES);
    if ({1'b0, r} < b) b = {1'b0, r};
    room = 33'd4096 - {21'd0, a[11:0]};
    if (room < b) b = room;
    return b[12:0];
  endfunction

  assign addr_after = cur_addr + {19'd0, burst};
  assign rem_after  = remaining - {19'd0, burst};
  assign in_wait    = (state == KEY_WAIT) || (state == RD_WAIT) || (state == WR_WAIT);
  assign active     = (state != IDLE) && (state != DONE) && (state != ERR);

  assign o_busy         = active;
  assign o_key_load     = (state == KEY_LOAD);
  assign o_rd_cmd_valid = (state == RD_CMD);
  assign o_wr_cmd_valid = (state == WR_CMD);
  assign o_rd_cmd_addr  = cur_addr;
  assign o_rd_cmd_len   = burst;
  assign o_wr_cmd_addr  = cur_addr;
  assign o_wr_cmd_len   = burst;

`ifdef SCHED_TIMEOUT_EN
  logic [31:0] wdog;
  assign wdog_hit = in_wait && (wdog == 32'(TIMEOUT_CYCLES));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             wdog <= '0;
    else if (nxt != state)  wdog <= '0;
    else if (in_wait)       wdog <= wdog + 32'd1;
  end
`else
  logic unused_timeout;
  assign wdog_hit       = 1'b0;
  assign unused_timeout = ^TIMEOUT_CYCLES ^ in_wait;
`endif

  always_comb begin
    nxt = state;
    case (state)
      IDLE:     if (i_start) nxt = CHECK;
      CHECK:    nxt = (remaining == 32'd0 || remaining[3:0] != 4'd0 || cur_addr[3:0] != 4'd0)
                      ? ERR : KEY_LOAD;
      KEY_LOAD: nxt = KEY_WAIT;
      KEY_WAIT: if (i_key_ready) nxt = RD_CMD;
      RD_CMD:   if (i_rd_cmd_ready) nxt = RD_WAIT;
      RD_WAIT:  if (i_rd_done) nxt = WR_CMD;
      WR_CMD:   if (i_wr_cmd_ready) nxt = WR_WAIT;
      WR_WAIT:  if (i_wr_done) nxt = (rem_after == 32'd0) ? DONE : RD_CMD;
      DONE:     nxt = IDLE;
      ERR:      nxt = IDLE;
      default:  nxt = IDLE;
    endcase
    // Error pulses override any done pulse seen on the same cycle.
    if (active && (i_rd_err || i_wr_err || wdog_hit)) nxt = ERR;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cur_addr   <= '0;
      remaining  <= '0;
      burst      <= '0;
      o_algo_sel <= 1'b0;
      o_enc_dec  <= 1'b0;
      o_key      <= '0;
      o_done     <= 1'b0;
      o_error    <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && i_start) begin
        cur_addr   <= i_base_addr;
        remaining  <= i_len;
        o_algo_sel <= i_algo_sel;
        o_enc_dec  <= i_enc_dec;
        o_key      <= i_key;
        o_done     <= 1'b0;
        o_error    <= 1'b0;
      end
      if (nxt == DONE) o_done  <= 1'b1;
      if (nxt == ERR)  o_error <= 1'b1;
      if (state == KEY_WAIT && nxt == RD_CMD) burst <= calc_burst(cur_addr, remaining);
      if (state == WR_WAIT && (nxt == RD_CMD || nxt == DONE)) begin
        cur_addr  <= addr_after;
        remaining <= rem_after;
        if (nxt == RD_CMD) burst <= calc_burst(addr_after, rem_after);
      end
    end
  end

endmodule

// File: tb/tb_crypto_job_sched.sv
// Bench for crypto_job_sched: vector table, hand corner cases and random jobs vs a burst-list model.
module tb_crypto_job_sched;

  logic         clk, rst_n;
  logic         i_start, i_algo_sel, i_enc_dec, i_key_ready;
  logic [31:0]  i_base_addr, i_len;
  logic [127:0] i_key;
  logic         o_key_load, o_algo_sel, o_enc_dec;
  logic [127:0] o_key;
  logic         o_rd_cmd_valid, i_rd_cmd_ready, i_rd_done, i_rd_err;
  logic [31:0]  o_rd_cmd_addr, o_wr_cmd_addr;
  logic [12:0]  o_rd_cmd_len, o_wr_cmd_len;
  logic         o_wr_cmd_valid, i_wr_cmd_ready, i_wr_done, i_wr_err;
  logic         o_busy, o_done, o_error;

  crypto_job_sched #(.MAX_BURST_BYTES(256), .TIMEOUT_CYCLES(65535)) dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_base_addr(i_base_addr), .i_len(i_len),
    .i_algo_sel(i_algo_sel), .i_enc_dec(i_enc_dec), .i_key(i_key),
    .o_key_load(o_key_load), .o_algo_sel(o_algo_sel), .o_enc_dec(o_enc_dec), .o_key(o_key),
    .i_key_ready(i_key_ready),
    .o_rd_cmd_valid(o_rd_cmd_valid), .i_rd_cmd_ready(i_rd_cmd_ready), .o_rd_cmd_addr(o_rd_cmd_addr),
    .o_rd_cmd_len(o_rd_cmd_len), .i_rd_done(i_rd_done), .i_rd_err(i_rd_err),
    .o_wr_cmd_valid(o_wr_cmd_valid), .i_wr_cmd_ready(i_wr_cmd_ready), .o_wr_cmd_addr(o_wr_cmd_addr),
    .o_wr_cmd_len(o_wr_cmd_len), .i_wr_done(i_wr_done), .i_wr_err(i_wr_err),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int n_kl;
  logic [31:0] obs_rd_a[$], obs_wr_a[$], exp_a[$];
  int          obs_rd_l[$], obs_wr_l[$], exp_l[$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] len;
    bit          exp_done;
    bit          exp_err;
    int          exp_nb;
  } vec_t;
  vec_t vecs[8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: job is legal if non-empty and 16B aligned; bursts are cut at MAX and 4KB lines.
  function automatic bit model(input logic [31:0] addr, input logic [31:0] len);
    longint a, r, b, room;
    exp_a.delete(); exp_l.delete();
    if (len == 0 || len % 16 != 0 || addr % 16 != 0) return 0;
    a = addr; r = len;
    while (r > 0) begin
      b = (r < 256) ? r : 256;
      room = 4096 - (a % 4096);
      if (room < b) b = room;
      exp_a.push_back(32'(a)); exp_l.push_back(int'(b));
      a = (a + b) % 64'h1_0000_0000;
      r = r - b;
    end
    return 1;
  endfunction

  task automatic clear_inputs();
    i_start = 0; i_rd_cmd_ready = 0; i_wr_cmd_ready = 0;
    i_rd_done = 0; i_rd_err = 0; i_wr_done = 0; i_wr_err = 0;
  endtask

  // Runs one job, playing crypto core and DMA with random latencies; records every command accepted.
  task automatic run_job(input logic [31:0] addr, input logic [31:0] len, input logic algo,
                         input logic ed, input logic [127:0] key, input int rd_hold,
                         input int err_burst, input bit busy_start, output int cyc);
    int rd_dn, wr_dn, kr_dly, bp_cnt;
    bit rd_pend, wr_pend;
    logic [31:0] h_addr;
    logic [12:0] h_len;
    obs_rd_a.delete(); obs_rd_l.delete(); obs_wr_a.delete(); obs_wr_l.delete();
    n_kl = 0; rd_pend = 0; wr_pend = 0; kr_dly = -1; bp_cnt = 0; rd_dn = 0; wr_dn = 0;
    h_addr = '0; h_len = '0;
    @(negedge clk);
    clear_inputs();
    i_key_ready = 0;
    i_base_addr = addr; i_len = len; i_algo_sel = algo; i_enc_dec = ed; i_key = key; i_start = 1;
    @(negedge clk);
    i_start = 0; i_base_addr = $urandom; i_len = $urandom; i_key = {4{$urandom}};
    i_algo_sel = ~algo; i_enc_dec = ~ed;
    cyc = 0;
    while (!(o_done || o_error) && cyc < 4000) begin
      clear_inputs();
      if (o_key_load) begin n_kl++; kr_dly = $urandom_range(0, 3); end
      else if (kr_dly > 0) kr_dly--;
      else if (kr_dly == 0) i_key_ready = 1;
      if (busy_start && cyc == 3) begin
        i_start = 1; i_base_addr = addr + 32'h100; i_len = 32'h20; i_key = ~key;
      end
      if (rd_pend) begin
        if (rd_dn == 0) begin i_rd_done = 1; rd_pend = 0; end else rd_dn--;
      end
      if (wr_pend) begin
        if (wr_dn == 0) begin
          i_wr_done = 1; wr_pend = 0;
          if (obs_wr_a.size() - 1 == err_burst) i_wr_err = 1;
        end else wr_dn--;
      end
      if (bp_cnt < rd_hold && (bp_cnt > 0 || o_rd_cmd_valid)) begin
        if (bp_cnt == 0) begin h_addr = o_rd_cmd_addr; h_len = o_rd_cmd_len; end
        else begin
          chk("bp_valid", o_rd_cmd_valid, 1);
          chk("bp_addr", o_rd_cmd_addr, h_addr);
          chk("bp_len", o_rd_cmd_len, h_len);
        end
        bp_cnt++;
      end else if (o_rd_cmd_valid && $urandom_range(0, 1) == 1) begin
        i_rd_cmd_ready = 1; rd_pend = 1; rd_dn = $urandom_range(0, 4);
        obs_rd_a.push_back(o_rd_cmd_addr); obs_rd_l.push_back(int'(o_rd_cmd_len));
      end
      if (o_wr_cmd_valid && $urandom_range(0, 1) == 1) begin
        i_wr_cmd_ready = 1; wr_pend = 1; wr_dn = $urandom_range(0, 4);
        obs_wr_a.push_back(o_wr_cmd_addr); obs_wr_l.push_back(int'(o_wr_cmd_len));
      end
      @(negedge clk);
      cyc++;
    end
    clear_inputs();
    i_key_ready = 0;
    if (cyc >= 4000) chk("job_timeout", 1, 0);
  endtask

  task automatic check_job(input string tag, input logic [31:0] addr, input logic [31:0] len,
                           input logic algo, input logic ed, input logic [127:0] key,
                           input bit exp_done, input bit exp_err, input int err_burst);
    bit ok;
    ok = model(addr, len);
    if (err_burst >= 0) while (exp_a.size() > err_burst + 1) begin
      void'(exp_a.pop_back()); void'(exp_l.pop_back());
    end
    chk({tag, "_done"}, o_done, exp_done);
    chk({tag, "_error"}, o_error, exp_err);
    chk({tag, "_keyload"}, n_kl, ok ? 1 : 0);
    chk({tag, "_key"}, o_key, key);
    chk({tag, "_mode"}, {o_algo_sel, o_enc_dec}, {algo, ed});
    chk({tag, "_nrd"}, obs_rd_a.size(), exp_a.size());
    chk({tag, "_nwr"}, obs_wr_a.size(), exp_a.size());
    for (int i = 0; i < exp_a.size() && i < obs_rd_a.size() && i < obs_wr_a.size(); i++) begin
      chk({tag, "_rd_addr"}, obs_rd_a[i], exp_a[i]);
      chk({tag, "_rd_len"}, obs_rd_l[i], exp_l[i]);
      chk({tag, "_wr_addr"}, obs_wr_a[i], exp_a[i]);
      chk({tag, "_wr_len"}, obs_wr_l[i], exp_l[i]);
    end
  endtask

  initial begin
    int cyc, k;
    logic [31:0] a, l;
    logic [127:0] key;
    logic alg, ed;
    bit ok;

    vecs[0] = '{32'h0000_1000, 32'h40,   1, 0, 1};
    vecs[1] = '{32'h0000_0F80, 32'h200,  1, 0, 3};
    vecs[2] = '{32'h0000_1000, 32'h24,   0, 1, 0};
    vecs[3] = '{32'h0000_2000, 32'h0,    0, 1, 0};
    vecs[4] = '{32'h0000_1008, 32'h40,   0, 1, 0};
    vecs[5] = '{32'h0000_0000, 32'h1000, 1, 0, 16};
    vecs[6] = '{32'h0000_FFF0, 32'h30,   1, 0, 2};
    vecs[7] = '{32'hFFFF_FFF0, 32'h20,   1, 0, 2};

    rst_n = 0; i_key_ready = 0; i_base_addr = 0; i_len = 0; i_algo_sel = 0; i_enc_dec = 0; i_key = 0;
    clear_inputs();
    repeat (3) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done_err", {o_done, o_error}, 0);
    chk("rst_valids", {o_key_load, o_rd_cmd_valid, o_wr_cmd_valid}, 0);
    chk("rst_key", o_key, 0);
    chk("rst_cmd", {o_rd_cmd_addr, o_rd_cmd_len, o_wr_cmd_addr, o_wr_cmd_len}, 0);
    rst_n = 1;

    for (int v = 0; v < 8; v++) begin
      key = {$urandom, $urandom, $urandom, $urandom};
      alg = 1'($urandom); ed = 1'($urandom);
      run_job(vecs[v].addr, vecs[v].len, alg, ed, key, 0, -1, 0, cyc);
      chk("vec_nbursts", obs_rd_a.size(), vecs[v].exp_nb);
      check_job("vec", vecs[v].addr, vecs[v].len, alg, ed, key, vecs[v].exp_done, vecs[v].exp_err, -1);
      if (vecs[v].exp_err) chk("err_latency_ok", cyc <= 2, 1);
    end

    // Completion pulses while idle must not disturb sticky status.
    @(negedge clk); i_rd_done = 1; i_rd_err = 1; i_wr_err = 1; i_wr_done = 1;
    @(negedge clk); clear_inputs();
    @(negedge clk);
    chk("idle_pulse_status", {o_busy, o_done, o_error}, 3'b010);

    key = 128'h0123_4567_89ab_cdef_0f1e_2d3c_4b5a_6978;
    run_job(32'h3000, 32'h100, 0, 1, key, 10, -1, 0, cyc);
    chk("bp_one_accept", obs_rd_a.size(), 1);
    check_job("bp", 32'h3000, 32'h100, 0, 1, key, 1, 0, -1);

    run_job(32'h4000, 32'h300, 1, 0, key, 0, -1, 1, cyc);
    check_job("busy_start", 32'h4000, 32'h300, 1, 0, key, 1, 0, -1);

    run_job(32'h5000, 32'h300, 1, 1, key, 0, 1, 0, cyc);
    check_job("err_prio", 32'h5000, 32'h300, 1, 1, key, 0, 1, 1);
    run_job(32'h6000, 32'h40, 0, 0, key, 0, -1, 0, cyc);
    check_job("after_err", 32'h6000, 32'h40, 0, 0, key, 1, 0, -1);

    // Asynchronous reset while a read burst is outstanding.
    @(negedge clk);
    i_key_ready = 1; i_base_addr = 32'h2000; i_len = 32'h100; i_key = ~key; i_start = 1;
    @(negedge clk); i_start = 0;
    k = 0;
    while (!o_rd_cmd_valid && k < 20) begin @(negedge clk); k++; end
    chk("rstmid_rd_valid", o_rd_cmd_valid, 1);
    i_rd_cmd_ready = 1;
    @(negedge clk); i_rd_cmd_ready = 0;
    @(negedge clk);
    chk("rstmid_busy_before", o_busy, 1);
    #2 rst_n = 0;
    #1;
    chk("rstmid_busy", o_busy, 0);
    chk("rstmid_status", {o_done, o_error, o_key_load, o_rd_cmd_valid, o_wr_cmd_valid}, 0);
    chk("rstmid_key", o_key, 0);
    chk("rstmid_cmd", {o_rd_cmd_addr, o_rd_cmd_len}, 0);
    @(negedge clk); rst_n = 1; i_key_ready = 0;
    run_job(32'h7000, 32'h80, 1, 0, key, 0, -1, 0, cyc);
    check_job("post_rst", 32'h7000, 32'h80, 1, 0, key, 1, 0, -1);

    for (int j = 0; j < 40; j++) begin
      a = $urandom & 32'hFFFF_FFF0;
      if ($urandom_range(0, 3) == 0) a = {a[31:12], 4'hF, 4'(($urandom_range(0, 15))), 4'h0};
      l = 32'($urandom_range(1, 96)) * 16;
      if ($urandom_range(0, 9) == 0) l = $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 15));
      key = {$urandom, $urandom, $urandom, $urandom};
      alg = 1'($urandom); ed = 1'($urandom);
      ok = model(a, l);
      run_job(a, l, alg, ed, key, 0, -1, 0, cyc);
      check_job("rand", a, l, alg, ed, key, ok, !ok, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/crypto_job_sched.md
Name: crypto_job_sched

Overview:
- Job sequencer between the AXI-Lite CSR block and the DMA read/write masters plus the AES/SM4 crypto core.
- On a start pulse it loads the 128-bit key and algorithm, then splits the job into 4KB-safe bursts.
- For each burst it issues a read command, waits for completion, then issues an in-place write command.
- Reports done/error/busy status back to the CSR.

Parameters:
- MAX_BURST_BYTES, 256, largest single DMA command in bytes; power of 2, range 16..4096.
- TIMEOUT_CYCLES, 65535, watchdog limit per wait state; used only with the optional feature.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- i_start  in  1  single-cycle job start pulse from CSR
- i_base_addr  in  32  job base byte address
- i_len  in  32  job length in bytes
- i_algo_sel  in  1  0=AES, 1=SM4
- i_enc_dec  in  1  0=encrypt, 1=decrypt
- i_key  in  128  key, {key3,key2,key1,key0}
- o_key_load  out  1  one-cycle key/mode load strobe to crypto core
- o_algo_sel  out  1  algo latched at start
- o_enc_dec  out  1  mode latched at start
- o_key  out  128  key latched at start
- i_key_ready  in  1  crypto key expansion complete (level)
- o_rd_cmd_valid  out  1  read command valid
- i_rd_cmd_ready  in  1  read command accepted
- o_rd_cmd_addr  out  32  read burst address
- o_rd_cmd_len  out  13  read burst bytes (1..4096)
- i_rd_done  in  1  read burst complete pulse
- i_rd_err  in  1  read burst error pulse
- o_wr_cmd_valid  out  1  write command valid
- i_wr_cmd_ready  in  1  write command accepted
- o_wr_cmd_addr  out  32  write burst address
- o_wr_cmd_len  out  13  write burst bytes
- i_wr_done  in  1  write burst complete pulse
- i_wr_err  in  1  write burst error pulse
- o_busy  out  1  job in progress
- o_done  out  1  sticky job-complete level
- o_error  out  1  sticky job-error level

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters and latches 0.
- States: IDLE, CHECK, KEY_LOAD, KEY_WAIT, RD_CMD, RD_WAIT, WR_CMD, WR_WAIT, DONE, ERR.
- IDLE + i_start:
  - Latch addr, len, algo, enc_dec, key.
  - Clear o_done and o_error.
  - Go to CHECK; o_busy=1 from the next cycle.
- CHECK: if len==0, len[3:0]!=0, or addr[3:0]!=0, go to ERR; else go to KEY_LOAD.
- KEY_LOAD: o_key_load=1 for exactly 1 cycle, then KEY_WAIT.
- KEY_WAIT: wait for i_key_ready=1, then RD_CMD.
- Burst size:
  - burst = min(MAX_BURST_BYTES, remaining, 4096 - cur_addr[11:0]).
  - Computed in 33-bit arithmetic, registered on entry to RD_CMD.
  - A burst never crosses a 4KB boundary.
- RD_CMD:
  - o_rd_cmd_valid=1 with addr/len held stable until i_rd_cmd_ready.
  - Accepted on the valid&ready cycle, then RD_WAIT.
- RD_WAIT: on i_rd_done go to WR_CMD, with write addr/len equal to the read burst (in-place).
- WR_CMD: same handshake rules as RD_CMD on the wr channel, then WR_WAIT.
- WR_WAIT on i_wr_done:
  - cur_addr += burst; remaining -= burst.
  - If remaining==0, go to DONE; else go to RD_CMD.
- DONE: o_done=1 (sticky), o_busy=0, return to IDLE in the same transition.
- ERR: o_error=1 (sticky), o_busy=0, return to IDLE.
- Errors:
  - i_rd_err/i_wr_err in any non-IDLE state go to ERR next cycle.
  - Error beats a simultaneous done pulse.
  - Done/err pulses arriving in IDLE are ignored.
- i_start while o_busy=1: ignored; latched config unchanged.
- Address arithmetic wraps modulo 2^32; no wrap detection.
- Async reset mid-job: everything returns to reset values immediately; in-flight commands are abandoned.

Optional Feature:
- SCHED_TIMEOUT_EN defined:
  - 32-bit watchdog clears on every state change and counts in KEY_WAIT, RD_WAIT, WR_WAIT.
  - When it reaches TIMEOUT_CYCLES, go to ERR.
- Undefined: no watchdog; wait states wait indefinitely. Counter logic is absent.

Test Plan:
- Single burst: start, addr=0x1000, len=0x40 -> 1 key_load pulse; rd cmd(0x1000,64), then wr cmd(0x1000,64); o_done=1, o_error=0.
- 4KB split: addr=0x0F80, len=0x200, MAX_BURST_BYTES=256 -> bursts (0x0F80,128), (0x1000,256), (0x1100,128), each read-then-write; o_done=1.
- Bad length: len=0x24 -> no key_load, no commands; o_error=1 within 3 cycles of start.
- Backpressure: hold i_rd_cmd_ready=0 for 10 cycles -> addr/len stable and valid high throughout; exactly one accept.
- Error priority: i_wr_done and i_wr_err asserted on the same cycle of the 2nd burst -> o_error=1, o_done=0, no 3rd read cmd; a new start afterwards clears o_error.
- Reset mid-job: rst_n low during RD_WAIT -> all outputs 0 asynchronously; after release, the next start runs a clean job.
